// File: rtl/axi_lite_write_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_write_master_if
// Purpose  : AXI4-Lite write-channel bundle (AW, W, B) shared by the write
//            master and whatever slave or bench sits on the other side.
// Params   : ADDR_WIDTH - AW address width
//            BUS_WIDTH  - W data width; wstrb width is BUS_WIDTH/8
// Modports : master - drives AW/W valid and payload and B ready
//            slave  - drives AW/W ready and the B response
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);

  logic                     m_axi_awvalid;
  logic                     m_axi_awready;
  logic [ADDR_WIDTH-1:0]    m_axi_awaddr;
  logic [2:0]               m_axi_awprot;

  logic                     m_axi_wvalid;
  logic                     m_axi_wready;
  logic [BUS_WIDTH-1:0]     m_axi_wdata;
  logic [BUS_WIDTH/8-1:0]   m_axi_wstrb;

  logic                     m_axi_bvalid;
  logic                     m_axi_bready;
  logic [1:0]               m_axi_bresp;

  modport master (
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_write_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_write_master
// Purpose  : Accepts words from an upstream valid/ready source and writes each
//            one to a single fixed AXI4-Lite address. One transaction is in
//            flight at a time: capture -> AW/W (independent) -> B response.
// Params   : ADDRESS    - fixed byte address placed on every AW beat
//            ADDR_WIDTH - AW address width
//            BUS_WIDTH  - data width (wstrb is BUS_WIDTH/8, always all ones)
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-high
//            valid_in / ready_in / data_in - upstream word handshake
//            m_axi      - AXI4-Lite write channels (master modport)
//            busy       - high whenever the engine is not idle
//            err_count  - saturating count of words dropped on error response
//            last_resp  - bresp of the most recent completed B handshake
// Options  : AXI_WRITE_MASTER_RETRY_EN - when defined, a non-OKAY response
//            reissues the same word up to 3 times before it is dropped.
//            When undefined, the first non-OKAY response drops the word.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_write_master #(
  parameter logic [31:0] ADDRESS    = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          BUS_WIDTH  = 32
) (
  input  wire logic                 clk,
  input  wire logic                 reset,

  input  wire logic                 valid_in,
  output logic                      ready_in,
  input  wire logic [BUS_WIDTH-1:0] data_in,

  axi_lite_write_master_if.master   m_axi,

  output logic                      busy,
  output logic [15:0]               err_count,
  output logic [1:0]                last_resp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic [1:0]  c_resp_okay = 2'b00;
  localparam logic [15:0] c_err_max   = 16'hFFFF;

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   aw_pend_q, aw_pend_d;
  logic                   w_pend_q, w_pend_d;
  logic [15:0]            err_count_q, err_count_d;
  logic [1:0]             last_resp_q, last_resp_d;
`ifdef AXI_WRITE_MASTER_RETRY_EN
  logic [1:0]             retry_cnt_q, retry_cnt_d;
`endif

  logic                   w_aw_fire;
  logic                   w_w_fire;
  logic [15:0]            w_err_inc;

  // Handshakes only count while the channel is actually being offered.
  assign w_aw_fire = (state_q == SEND) && aw_pend_q && m_axi.m_axi_awready;
  assign w_w_fire  = (state_q == SEND) && w_pend_q  && m_axi.m_axi_wready;

  // Saturating increment for the dropped-word counter.
  assign w_err_inc = (err_count_q == c_err_max) ? err_count_q : err_count_q + 16'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      err_count_q <= '0;
      last_resp_q <= c_resp_okay;
`ifdef AXI_WRITE_MASTER_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      err_count_q <= err_count_d;
      last_resp_q <= last_resp_d;
`ifdef AXI_WRITE_MASTER_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    err_count_d = err_count_q;
    last_resp_d = last_resp_q;
`ifdef AXI_WRITE_MASTER_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // ready_in is 1 throughout IDLE, so valid_in alone is the handshake.
        if (valid_in) begin
          data_d    = data_in;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
`ifdef AXI_WRITE_MASTER_RETRY_EN
          retry_cnt_d = '0;
`endif
          state_d   = SEND;
        end
      end

      SEND: begin
        if (w_aw_fire) aw_pend_d = 1'b0;
        if (w_w_fire)  w_pend_d  = 1'b0;
        // Leave once both channels are done, whichever order they finished in.
        if (!aw_pend_d && !w_pend_d) state_d = WAIT_RSP;
      end

      WAIT_RSP: begin
        if (m_axi.m_axi_bvalid) begin
          last_resp_d = m_axi.m_axi_bresp;
          if (m_axi.m_axi_bresp == c_resp_okay) begin
            state_d = IDLE;
          end else begin
`ifdef AXI_WRITE_MASTER_RETRY_EN
            // retry_cnt counts reissues already made; the 3rd failing retry drops.
            if (retry_cnt_q == 2'd3) begin
              err_count_d = w_err_inc;
              state_d     = IDLE;
            end else begin
              retry_cnt_d = retry_cnt_q + 2'd1;
              aw_pend_d   = 1'b1;
              w_pend_d    = 1'b1;
              state_d     = SEND;
            end
`else
            err_count_d = w_err_inc;
            state_d     = IDLE;
`endif
          end
        end
      end

      default: begin
        state_d   = IDLE;
        aw_pend_d = 1'b0;
        w_pend_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded straight from flops so reset clears them immediately.
  // --------------------------------------------------------------------------
  assign ready_in  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign err_count = err_count_q;
  assign last_resp = last_resp_q;

  assign m_axi.m_axi_awvalid = (state_q == SEND) && aw_pend_q;
  assign m_axi.m_axi_awaddr  = ADDRESS[ADDR_WIDTH-1:0];
  assign m_axi.m_axi_awprot  = 3'b000;

  assign m_axi.m_axi_wvalid  = (state_q == SEND) && w_pend_q;
  assign m_axi.m_axi_wdata   = data_q;
  assign m_axi.m_axi_wstrb   = '1;

  assign m_axi.m_axi_bready  = (state_q == WAIT_RSP);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_write_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_write_master
// Purpose  : Directed self-checking bench for axi_lite_write_master with a
//            small behavioural AXI4-Lite slave (B returned the cycle after the
//            later of AW/W, responses taken from a queue, OKAY when empty).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_write_master;

  localparam logic [31:0] c_addr = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic        busy;
  logic [15:0] err_count;
  logic [1:0]  last_resp;

  axi_lite_write_master_if #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) axi ();

  axi_lite_write_master #(
    .ADDRESS    (c_addr),
    .ADDR_WIDTH (32),
    .BUS_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .m_axi     (axi),
    .busy      (busy),
    .err_count (err_count),
    .last_resp (last_resp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Slave model state
  int          aw_cnt = 0;
  int          b_cnt  = 0;
  int          strb_bad = 0;
  logic [31:0] awaddr_last = '0;
  logic [31:0] w_log[$];
  logic [1:0]  resp_q[$];
  logic        aw_seen, w_seen;
  logic        s_aw_done, s_w_done;
  logic        b_hold = 1'b0;
  int          err_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      axi.m_axi_bvalid <= 1'b0;
      axi.m_axi_bresp  <= 2'b00;
      aw_seen          <= 1'b0;
      w_seen           <= 1'b0;
    end else begin
      if (axi.m_axi_bvalid && axi.m_axi_bready) begin
        axi.m_axi_bvalid <= 1'b0;
        b_cnt <= b_cnt + 1;
      end
      if (axi.m_axi_awvalid && axi.m_axi_awready) begin
        aw_cnt      <= aw_cnt + 1;
        awaddr_last <= axi.m_axi_awaddr;
      end
      if (axi.m_axi_wvalid && axi.m_axi_wready) begin
        w_log.push_back(axi.m_axi_wdata);
        if (axi.m_axi_wstrb !== 4'hF) strb_bad <= strb_bad + 1;
      end
      s_aw_done = aw_seen || (axi.m_axi_awvalid && axi.m_axi_awready);
      s_w_done  = w_seen  || (axi.m_axi_wvalid  && axi.m_axi_wready);
      if (s_aw_done && s_w_done && !b_hold && !axi.m_axi_bvalid) begin
        axi.m_axi_bvalid <= 1'b1;
        axi.m_axi_bresp  <= (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        aw_seen <= s_aw_done;
        w_seen  <= s_w_done;
      end
    end
  end

  // Offer a word and return once it has been captured (bounded wait).
  task automatic send_word(input logic [31:0] d, output int cap_cyc);
    bit done;
    done    = 1'b0;
    cap_cyc = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = d;
      if (ready_in === 1'b1) begin
        @(posedge clk);
        #1;
        cap_cyc  = cyc;
        valid_in = 1'b0;
        done     = 1'b1;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      valid_in = 1'b0;
      $display("FAIL send_word_timeout data=%h observed_captured=0 expected_captured=1", d);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    tests++;
    if (!idle) begin
      fails++;
      $display("FAIL %s_idle_timeout observed_busy=%b expected_busy=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    axi.m_axi_awready = 1'b1;
    axi.m_axi_wready  = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (axi.m_axi_awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid observed=%b expected=0", axi.m_axi_awvalid); end
    tests++;
    if (axi.m_axi_wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid observed=%b expected=0", axi.m_axi_wvalid); end
    tests++;
    if (axi.m_axi_bready !== 1'b0) begin fails++; $display("FAIL reset_bready observed=%b expected=0", axi.m_axi_bready); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy observed=%b expected=0", busy); end
    tests++;
    if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count observed=%0d expected=0", err_count); end
    tests++;
    if (last_resp !== 2'b00) begin fails++; $display("FAIL reset_last_resp observed=%b expected=00", last_resp); end
    tests++;
    if (axi.m_axi_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata observed=%h expected=0", axi.m_axi_wdata); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ready_in !== 1'b1) begin fails++; $display("FAIL reset_ready_in observed=%b expected=1", ready_in); end
  endtask

  task automatic test_single();
    int aw0, b0, w0, c;
    aw0 = aw_cnt; b0 = b_cnt; w0 = w_log.size();
    send_word(32'hDEAD_BEEF, c);
    wait_idle("single");
    tests++;
    if (aw_cnt !== aw0 + 1) begin fails++; $display("FAIL single_aw_beats observed=%0d expected=%0d", aw_cnt - aw0, 1); end
    tests++;
    if (awaddr_last !== c_addr) begin fails++; $display("FAIL single_awaddr observed=%h expected=%h", awaddr_last, c_addr); end
    tests++;
    if (w_log.size() !== w0 + 1 || w_log[w_log.size()-1] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL single_wdata observed=%h expected=deadbeef", w_log[w_log.size()-1]);
    end
    tests++;
    if (strb_bad !== 0) begin fails++; $display("FAIL single_wstrb observed_bad=%0d expected_bad=0", strb_bad); end
    tests++;
    if (axi.m_axi_awprot !== 3'b000) begin fails++; $display("FAIL single_awprot observed=%b expected=000", axi.m_axi_awprot); end
    tests++;
    if (b_cnt !== b0 + 1) begin fails++; $display("FAIL single_b_count observed=%0d expected=1", b_cnt - b0); end
    tests++;
    if (err_count !== 16'd0) begin fails++; $display("FAIL single_err_count observed=%0d expected=0", err_count); end
  endtask

  task automatic test_aw_stall();
    int aw0, b0, w0, c, bad;
    aw0 = aw_cnt; b0 = b_cnt; w0 = w_log.size(); bad = 0;
    axi.m_axi_awready = 1'b0;
    send_word(32'h1234_5678, c);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (axi.m_axi_awvalid !== 1'b1 || axi.m_axi_awaddr !== c_addr || ready_in !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL stall_aw_stable observed_bad_cycles=%0d expected=0", bad); end
    tests++;
    if (w_log.size() !== w0 + 1 || aw_cnt !== aw0 || axi.m_axi_wvalid !== 1'b0) begin
      fails++; $display("FAIL stall_w_first observed_w=%0d observed_aw=%0d expected_w=1 expected_aw=0", w_log.size() - w0, aw_cnt - aw0);
    end
    axi.m_axi_awready = 1'b1;
    wait_idle("stall");
    tests++;
    if (aw_cnt !== aw0 + 1 || b_cnt !== b0 + 1) begin
      fails++; $display("FAIL stall_beats observed_aw=%0d observed_b=%0d expected=1/1", aw_cnt - aw0, b_cnt - b0);
    end
    tests++;
    if (w_log[w_log.size()-1] !== 32'h1234_5678) begin fails++; $display("FAIL stall_wdata observed=%h expected=12345678", w_log[w_log.size()-1]); end
  endtask

  task automatic test_error_once();
    int aw0, c;
    aw0 = aw_cnt;
    resp_q.push_back(2'b10);
    send_word(32'hCAFE_0001, c);
    wait_idle("err1");
`ifdef AXI_WRITE_MASTER_RETRY_EN
    tests++;
    if (aw_cnt !== aw0 + 2) begin fails++; $display("FAIL err1_aw_beats observed=%0d expected=2", aw_cnt - aw0); end
    tests++;
    if (err_count !== 16'(err_exp)) begin fails++; $display("FAIL err1_err_count observed=%0d expected=%0d", err_count, err_exp); end
    tests++;
    if (last_resp !== 2'b00) begin fails++; $display("FAIL err1_last_resp observed=%b expected=00", last_resp); end
`else
    err_exp++;
    tests++;
    if (aw_cnt !== aw0 + 1) begin fails++; $display("FAIL err1_aw_beats observed=%0d expected=1", aw_cnt - aw0); end
    tests++;
    if (err_count !== 16'(err_exp)) begin fails++; $display("FAIL err1_err_count observed=%0d expected=%0d", err_count, err_exp); end
    tests++;
    if (last_resp !== 2'b10) begin fails++; $display("FAIL err1_last_resp observed=%b expected=10", last_resp); end
`endif
  endtask

  task automatic test_retry_exhaust();
    int aw0, c, exp_aw;
    aw0 = aw_cnt;
    repeat (4) resp_q.push_back(2'b11);
    send_word(32'hCAFE_0002, c);
    wait_idle("exhaust");
`ifdef AXI_WRITE_MASTER_RETRY_EN
    exp_aw = 4;
`else
    exp_aw = 1;
`endif
    err_exp++;
    tests++;
    if (aw_cnt !== aw0 + exp_aw) begin fails++; $display("FAIL exhaust_aw_beats observed=%0d expected=%0d", aw_cnt - aw0, exp_aw); end
    tests++;
    if (err_count !== 16'(err_exp)) begin fails++; $display("FAIL exhaust_err_count observed=%0d expected=%0d", err_count, err_exp); end
    tests++;
    if (last_resp !== 2'b11 || ready_in !== 1'b1) begin
      fails++; $display("FAIL exhaust_final observed_resp=%b observed_ready=%b expected=11/1", last_resp, ready_in);
    end
    resp_q.delete();
  endtask

  task automatic test_reset_mid();
    int b0, c;
    bit seen;
    b_hold = 1'b1;
    seen   = 1'b0;
    send_word(32'hAAAA_5555, c);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (axi.m_axi_bready === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL rstmid_reach_wait observed_bready=%b expected=1", axi.m_axi_bready); end
    rst = 1'b1;
    #1;
    tests++;
    if ({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, busy} !== 4'b0000) begin
      fails++; $display("FAIL rstmid_outputs observed=%b expected=0000",
                        {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, busy});
    end
    tests++;
    if (err_count !== 16'd0) begin fails++; $display("FAIL rstmid_err_count observed=%0d expected=0", err_count); end
    @(negedge clk);
    rst     = 1'b0;
    b_hold  = 1'b0;
    err_exp = 0;
    b0 = b_cnt;
    send_word(32'h0000_0077, c);
    wait_idle("rstmid");
    tests++;
    if (w_log[w_log.size()-1] !== 32'h0000_0077 || b_cnt !== b0 + 1) begin
      fails++; $display("FAIL rstmid_next_word observed=%h b=%0d expected=00000077 b=1", w_log[w_log.size()-1], b_cnt - b0);
    end
    tests++;
    if (err_count !== 16'd0 || last_resp !== 2'b00) begin
      fails++; $display("FAIL rstmid_status observed_err=%0d observed_resp=%b expected=0/00", err_count, last_resp);
    end
  endtask

  task automatic test_back_to_back();
    int w0, bad_order, max_gap;
    int cap[8];
    w0 = w_log.size();
    for (int i = 0; i < 8; i++) send_word(32'(i + 1), cap[i]);
    wait_idle("b2b");
    max_gap = 0;
    for (int i = 1; i < 8; i++) if (cap[i] - cap[i-1] > max_gap) max_gap = cap[i] - cap[i-1];
    tests++;
    if (max_gap > 3) begin fails++; $display("FAIL b2b_gap observed_max=%0d expected_max=3", max_gap); end
    tests++;
    if (w_log.size() !== w0 + 8) begin fails++; $display("FAIL b2b_count observed=%0d expected=8", w_log.size() - w0); end
    bad_order = 0;
    for (int i = 0; i < 8 && (w0 + i) < w_log.size(); i++)
      if (w_log[w0 + i] !== 32'(i + 1)) bad_order++;
    tests++;
    if (bad_order !== 0) begin fails++; $display("FAIL b2b_order observed_bad=%0d expected=0", bad_order); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_aw_stall();
    test_error_once();
    test_retry_exhaust();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
